// File: rtl/message_seq_ctrl.sv
// Timing sequencer for the multi-channel message generator.
// Walks the chip / repeat / message-bit odometer on every accepted DAC sample.
// Sequences start (immediate or aligned to a UTC second edge), graceful stop at a
// frame boundary, and immediate abort. Also emits the bit and frame markers.
module message_seq_ctrl #(
    parameter int PCODE_LEN     = 40920,
    parameter int PCODE_REPEATS = 10,
    parameter int MESSAGE_LEN   = 120,
    parameter int CHIP_DIV      = 1,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run_req,
    input  logic                           start_align,
    input  logic                           abort,
    input  logic                           sample_en,
    input  logic                           sys_time_sync_done,
    input  logic [5:0]                     sys_utc_time_second,
    output logic [$clog2(PCODE_LEN)-1:0]   pcode_addr,
    output logic [$clog2(MESSAGE_LEN)-1:0] msg_addr,
    output logic                           dac_valid,
    output logic                           bit_start,
    output logic                           frame_start,
    output logic                           frame_end,
    output logic                           busy,
    output logic [1:0]                     state,
    output logic [FRAME_CNT_W-1:0]         frame_count
);

    localparam int PA_W  = $clog2(PCODE_LEN);
    localparam int MA_W  = $clog2(MESSAGE_LEN);
    localparam int DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int REP_W = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CHIP_DIV - 1);
    localparam logic [PA_W-1:0]  PC_MAX  = PA_W'(PCODE_LEN - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(PCODE_REPEATS - 1);
    localparam logic [MA_W-1:0]  MSG_MAX = MA_W'(MESSAGE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    state_t                 r_state;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [PA_W-1:0]        r_pcode_addr;
    logic [REP_W-1:0]       r_rep_cnt;
    logic [MA_W-1:0]        r_msg_addr;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic [5:0]             r_sec_prev;
    logic                   r_sec_prev_vld;

    logic                   w_active;
    logic                   w_dac_valid;
    logic                   w_div_max;
    logic                   w_pc_max;
    logic                   w_rep_max;
    logic                   w_msg_max;
    logic                   w_bit_start;
    logic                   w_frame_end;
    logic                   w_sec_tick;
    logic [DIV_W-1:0]       w_div_next;
    logic [PA_W-1:0]        w_pcode_next;
    logic [REP_W-1:0]       w_rep_next;
    logic [MA_W-1:0]        w_msg_next;

    // Samples are only consumed while transmitting; abort kills the current slot.
    assign w_active    = (r_state == ST_RUN) || (r_state == ST_STOPPING);
    assign w_dac_valid = w_active && sample_en && !abort;

    assign w_div_max = (r_div_cnt == DIV_MAX);
    assign w_pc_max  = (r_pcode_addr == PC_MAX);
    assign w_rep_max = (r_rep_cnt == REP_MAX);
    assign w_msg_max = (r_msg_addr == MSG_MAX);

    assign w_bit_start = w_dac_valid && (r_div_cnt == '0) && (r_pcode_addr == '0) && (r_rep_cnt == '0);
    assign w_frame_end = w_dac_valid && w_div_max && w_pc_max && w_rep_max && w_msg_max;
    assign w_sec_tick  = r_sec_prev_vld && (sys_utc_time_second != r_sec_prev);

    // Odometer next-position: each stage steps only when every lower stage wraps.
    always_comb begin
        w_div_next   = w_div_max ? '0 : r_div_cnt + 1'b1;
        w_pcode_next = r_pcode_addr;
        w_rep_next   = r_rep_cnt;
        w_msg_next   = r_msg_addr;
        if (w_div_max) begin
            w_pcode_next = w_pc_max ? '0 : r_pcode_addr + 1'b1;
            if (w_pc_max) begin
                w_rep_next = w_rep_max ? '0 : r_rep_cnt + 1'b1;
                if (w_rep_max) begin
                    w_msg_next = w_msg_max ? '0 : r_msg_addr + 1'b1;
                end
            end
        end
    end

    // Track the previous UTC second so a change can be seen as a second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_prev     <= '0;
            r_sec_prev_vld <= 1'b0;
        end else begin
            r_sec_prev     <= sys_utc_time_second;
            r_sec_prev_vld <= 1'b1;
        end
    end

    // Sequencer FSM with position counters and completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_div_cnt     <= '0;
            r_pcode_addr  <= '0;
            r_rep_cnt     <= '0;
            r_msg_addr    <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (w_dac_valid) begin
                r_div_cnt    <= w_div_next;
                r_pcode_addr <= w_pcode_next;
                r_rep_cnt    <= w_rep_next;
                r_msg_addr   <= w_msg_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (run_req && !abort) begin
                        r_state <= start_align ? ST_ARMED : ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (abort || !run_req) begin
                        r_state <= ST_IDLE;
                    end else if (sys_time_sync_done && w_sec_tick) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state      <= ST_IDLE;
                        r_div_cnt    <= '0;
                        r_pcode_addr <= '0;
                        r_rep_cnt    <= '0;
                        r_msg_addr   <= '0;
                    end else if (!run_req) begin
                        r_state <= ST_STOPPING;
                    end
                end
                ST_STOPPING: begin
                    // Re-request wins over the frame boundary; counters wrap naturally.
                    if (abort || (!run_req && w_frame_end)) begin
                        r_state      <= ST_IDLE;
                        r_div_cnt    <= '0;
                        r_pcode_addr <= '0;
                        r_rep_cnt    <= '0;
                        r_msg_addr   <= '0;
                    end else if (run_req) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pcode_addr  = r_pcode_addr;
    assign msg_addr    = r_msg_addr;
    assign dac_valid   = w_dac_valid;
    assign bit_start   = w_bit_start;
    assign frame_start = w_bit_start && (r_msg_addr == '0);
    assign frame_end   = w_frame_end;
    assign busy        = (r_state != ST_IDLE);
    assign state       = r_state;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_message_seq_ctrl.sv
// Self-checking bench for message_seq_ctrl with a frame-position reference model.
// The driver pushes per-cycle expectations; a separate monitor pops and compares.
module tb_message_seq_ctrl;

    localparam int PL  = 4;
    localparam int PR  = 2;
    localparam int ML  = 3;
    localparam int CD  = 2;
    localparam int FW  = 16;
    localparam int SPB = CD * PL * PR;   // samples per message bit
    localparam int SPF = SPB * ML;       // samples per frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_req = 1'b0;
    logic        start_align = 1'b0;
    logic        abort = 1'b0;
    logic        sample_en = 1'b0;
    logic        sys_time_sync_done = 1'b0;
    logic [5:0]  sys_utc_time_second = 6'd0;
    logic [1:0]  pcode_addr;
    logic [1:0]  msg_addr;
    logic        dac_valid;
    logic        bit_start;
    logic        frame_start;
    logic        frame_end;
    logic        busy;
    logic [1:0]  state;
    logic [FW-1:0] frame_count;

    message_seq_ctrl #(
        .PCODE_LEN(PL), .PCODE_REPEATS(PR), .MESSAGE_LEN(ML),
        .CHIP_DIV(CD), .FRAME_CNT_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .start_align(start_align),
        .abort(abort), .sample_en(sample_en), .sys_time_sync_done(sys_time_sync_done),
        .sys_utc_time_second(sys_utc_time_second),
        .pcode_addr(pcode_addr), .msg_addr(msg_addr), .dac_valid(dac_valid),
        .bit_start(bit_start), .frame_start(frame_start), .frame_end(frame_end),
        .busy(busy), .state(state), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int valid; int pcode; int msg; int fc; } cyc_t;
    typedef struct { int bs; int fs; int fe; } smp_t;

    cyc_t cyc_q[$];
    smp_t smp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur_sec  = 0;

    // Reference model: mode plus linear sample index within the frame.
    int m_state;
    int m_k;
    int m_fc;
    int m_sec_prev;
    bit m_sec_vld;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_dac_valid"}, int'(dac_valid), 0);
        chk({tag, "_pcode"}, int'(pcode_addr), 0);
        chk({tag, "_msg"}, int'(msg_addr), 0);
        chk({tag, "_frame_count"}, int'(frame_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_markers"}, int'({bit_start, frame_start, frame_end}), 0);
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_k       = 0;
        m_fc      = 0;
        m_sec_prev = 0;
        m_sec_vld = 1'b0;
    endtask

    // One clock cycle of the model, using the inputs currently applied.
    task automatic step();
        cyc_t c;
        smp_t s;
        bit tick, valid, done;
        tick = m_sec_vld && (int'(sys_utc_time_second) != m_sec_prev);
        m_sec_prev = int'(sys_utc_time_second);
        m_sec_vld  = 1'b1;
        valid = (m_state == 2 || m_state == 3) && sample_en && !abort;
        c.st    = m_state;
        c.valid = valid;
        c.pcode = (m_k / CD) % PL;
        c.msg   = m_k / SPB;
        c.fc    = m_fc;
        cyc_q.push_back(c);
        if (valid) begin
            s.bs = (m_k % SPB) == 0;
            s.fs = (m_k == 0);
            s.fe = (m_k == SPF - 1);
            smp_q.push_back(s);
        end
        done = valid && (m_k == SPF - 1);
        if (valid) m_k = (m_k + 1) % SPF;
        if (done) m_fc = (m_fc + 1) % (1 << FW);
        case (m_state)
            0: if (run_req && !abort) m_state = start_align ? 1 : 2;
            1: begin
                if (abort || !run_req) m_state = 0;
                else if (sys_time_sync_done && tick) m_state = 2;
            end
            2: begin
                if (abort) m_state = 0;
                else if (!run_req) m_state = 3;
            end
            default: begin
                if (abort) m_state = 0;
                else if (run_req) m_state = 2;
                else if (done) m_state = 0;
            end
        endcase
        if (m_state == 0) m_k = 0;
    endtask

    task automatic drive(bit rr, bit al, bit ab, bit se, bit sy);
        @(negedge clk);
        run_req             = rr;
        start_align         = al;
        abort               = ab;
        sample_en           = se;
        sys_time_sync_done  = sy;
        sys_utc_time_second = 6'(cur_sec % 60);
        step();
    endtask

    // Monitor: compares every cycle's observable outputs against the scoreboard.
    initial begin
        cyc_t c;
        smp_t s;
        int prev_st;
        prev_st = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk_reset_outputs("in_reset");
                prev_st = 0;
            end else if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                if (c.st != prev_st)
                    $display("[%0t] state %0d -> %0d, frame_count=%0d", $time, prev_st, c.st, c.fc);
                prev_st = c.st;
                chk("state", int'(state), c.st);
                chk("busy", int'(busy), int'(c.st != 0));
                chk("dac_valid", int'(dac_valid), c.valid);
                chk("pcode_addr", int'(pcode_addr), c.pcode);
                chk("msg_addr", int'(msg_addr), c.msg);
                chk("frame_count", int'(frame_count), c.fc);
                if (c.valid != 0) begin
                    s = smp_q.pop_front();
                    chk("bit_start", int'(bit_start), s.bs);
                    chk("frame_start", int'(frame_start), s.fs);
                    chk("frame_end", int'(frame_end), s.fe);
                end else begin
                    chk("markers_without_sample", int'({bit_start, frame_start, frame_end}), 0);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        bit rr, al, ab, se, sy, once;
        model_reset();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle after reset: nothing happens without run_req.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cur_sec++;
            drive(0, 0, 0, 1, 1);
        end

        // Immediate start, continuous samples, a little over two frames.
        for (int i = 0; i < 110; i++) drive(1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1);

        // sample_en alternating: counters advance only on accepted slots.
        for (int i = 0; i < 110; i++) drive(1, 0, 0, (i % 2) == 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);

        // Graceful stop requested at sample 10; runs to the frame end.
        rr = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (m_state == 2 && m_k == 10) rr = 1'b0;
            drive(rr, 0, 0, 1, 1);
        end

        // Stop at sample 10, re-request at sample 20 while stopping.
        rr = 1'b1;
        once = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!once && m_state == 2 && m_k == 10) begin rr = 1'b0; once = 1'b1; end
            if (m_state == 3 && m_k == 20) rr = 1'b1;
            drive(rr, 0, 0, 1, 1);
        end

        // Run a frame, then abort at sample 25 in the second one.
        for (int i = 0; i < 80; i++) begin
            ab = (m_state == 2 && m_k == 25 && m_fc > 0);
            drive(!ab, 0, ab, 1, 1);
        end
        drive(0, 0, 0, 1, 1);

        // Aligned start: no time sync -> remains armed across second changes.
        cur_sec = 5;
        drive(1, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) cur_sec++;
            drive(1, 1, 0, 1, 0);
        end
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 1);
        cur_sec++;
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 1, 1);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 0, 1, 1);

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 1, 1);
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        run_req = 1'b0;
        model_reset();
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cur_sec++;
            drive(0, 1, 0, 1, 1);
        end

        // Randomized traffic.
        rr = 1'b1; al = 1'b0; sy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) rr = !rr;
            if ($urandom_range(0, 19) == 0) al = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 149) == 0);
            se = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) sy = !sy;
            if ($urandom_range(0, 24) == 0) cur_sec++;
            drive(rr, al, ab, se, sy);
        end
        drive(0, 0, 1, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 1);

        #4;
        chk("cycle_queue_drained", cyc_q.size(), 0);
        chk("sample_queue_drained", smp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/message_seq_ctrl.md
Name: message_seq_ctrl

Overview:
- Timing sequencer for the multi-channel message generator.
- Produces the shared pcode chip address and message bit address, plus the sample-valid strobe that clocks the generator datapath.
- Handles start (immediate, or aligned to a UTC second edge after time sync), graceful stop at frame boundary, and immediate abort.
- Emits bit/frame markers used by timestamp patching and status logic.

Parameters:
- PCODE_LEN, 40920, chips per pcode period.
- PCODE_REPEATS, 10, pcode periods per message bit.
- MESSAGE_LEN, 120, message bits per frame.
- CHIP_DIV, 1, accepted samples per chip (>=1).
- FRAME_CNT_W, 16, width of frame counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run_req  in  1  level; 1 = transmit requested.
- start_align  in  1  0 = start immediately, 1 = wait for second edge.
- abort  in  1  pulse; immediate stop.
- sample_en  in  1  DAC sample slot available this cycle.
- sys_time_sync_done  in  1  UTC time valid.
- sys_utc_time_second  in  6  current UTC second.
- pcode_addr  out  $clog2(PCODE_LEN)  current chip index.
- msg_addr  out  $clog2(MESSAGE_LEN)  current message bit index.
- dac_valid  out  1  sample consumed this cycle.
- bit_start  out  1  first sample of a message bit.
- frame_start  out  1  first sample of a frame.
- frame_end  out  1  last sample of a frame.
- busy  out  1  state != IDLE.
- state  out  2  IDLE=0, ARMED=1, RUN=2, STOPPING=3.
- frame_count  out  FRAME_CNT_W  completed frames, wraps.

Behaviour:
- Reset: state IDLE; all counters, addresses and frame_count 0; all pulses 0; sec_prev_vld 0.
- Internal counters: div_cnt (0..CHIP_DIV-1) and rep_cnt (0..PCODE_REPEATS-1). pcode_addr and msg_addr are registered.
- dac_valid = (state==RUN or STOPPING) && sample_en && !abort. This is combinational from registered state.
- Addresses on a dac_valid cycle identify that sample.
- Advance on dac_valid, odometer order:
  - div_cnt wraps -> pcode_addr+1.
  - pcode_addr wraps at PCODE_LEN-1 -> rep_cnt+1.
  - rep_cnt wraps -> msg_addr+1.
  - msg_addr wraps at MESSAGE_LEN-1 -> frame complete.
  - Every wrap returns the counter to 0; no counter ever exceeds its bound.
- Marker pulses (combinational, qualified by dac_valid):
  - bit_start = div_cnt, pcode_addr and rep_cnt all 0.
  - frame_start = bit_start && msg_addr==0.
  - frame_end = all counters at their maxima.
- frame_count increments on the edge after frame_end and wraps at 2^FRAME_CNT_W. Only reset clears it.
- Second-edge detect: sec_prev registers sys_utc_time_second every cycle; sec_prev_vld is set 1 cycle after reset. sec_tick = sec_prev_vld && (second != sec_prev).
- FSM transitions:
  - IDLE: run_req && !start_align -> RUN. run_req && start_align -> ARMED. Counters held at 0.
  - ARMED: abort or !run_req -> IDLE. Else sys_time_sync_done && sec_tick -> RUN. No samples are consumed in ARMED.
  - RUN: abort -> IDLE. Else !run_req -> STOPPING. Loss of sys_time_sync_done has no effect.
  - STOPPING: keeps consuming samples. The edge after frame_end -> IDLE. abort -> IDLE. run_req re-asserted -> RUN, with no counter disturbance.
  - Leaving to IDLE (any cause): all position counters cleared to 0 on that edge.
  - Abort cycle: dac_valid=0 and no advance.
- Simultaneous events:
  - abort has priority over everything.
  - frame_end in STOPPING with run_req re-asserted in the same cycle -> RUN, counters wrap to 0.
  - sample_en=0 stalls all counters; state transitions still occur.
- First sample after entering RUN is the frame_start sample. Latency from RUN entry to first dac_valid is 0 cycles if sample_en=1.

Test Plan:
All scenarios use PCODE_LEN=4, PCODE_REPEATS=2, MESSAGE_LEN=3, CHIP_DIV=2 (48 samples/frame).
- Reset mid-RUN: drop rst_n asynchronously -> all outputs 0 and state=0 immediately. After release, state stays IDLE until run_req.
- Immediate start, sample_en=1 continuously -> frame_start at sample 0; bit_start at samples 0, 16, 32; frame_end at sample 47; frame_start again at 48; frame_count=1 after 48 samples. pcode_addr sequence is 0,0,1,1,2,2,3,3,0,...
- sample_en toggling 1,0,1,0 -> addresses advance only on the 1 cycles; frame_end at the 48th accepted sample (cycle 95).
- start_align=1, sync_done=0, second changing -> stays ARMED. Raise sync_done; on the next second change -> RUN the following edge, with frame_start on the first sample.
- Drop run_req at sample 10 -> state=3; runs to sample 47 with frame_end, then IDLE, all addresses 0, frame_count+1. Re-asserting run_req at sample 20 returns to RUN with no gap.
- Abort at sample 25 -> dac_valid=0 that cycle, IDLE next edge, counters 0, frame_count unchanged.
